// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package data_mem_responder_pkg;

  localparam int unsigned DEFAULT_LATENCY   = 4;
  localparam int unsigned DEFAULT_NUM_WORDS = 16384;
  localparam int unsigned DATA_W            = 32;
  localparam int unsigned CNT_W             = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Request payload held for the duration of an access.
  typedef struct packed {
    logic              is_write;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  function automatic int unsigned idx_width(input int unsigned num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

endpackage

// File: rtl/data_mem_responder_latency_counter.sv
// Loadable down-counter that times the BUSY window; zero flag ends the wait.
module data_mem_responder_latency_counter
  import data_mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec_en,
  output logic             zero_c
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec_en && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side end of the MEM-stage load/store handshake: accepts one request,
// waits LATENCY edges, then performs the access and pulses is_output_valid.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned NUM_WORDS = DEFAULT_NUM_WORDS,
  parameter int unsigned LATENCY   = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_input_valid,
  input  logic [31:0] addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] din,
  output logic        mem_ready,
  output logic        is_output_valid,
  output logic [31:0] dout,
  output logic        is_busy
);

  localparam int unsigned IDX_W         = idx_width(NUM_WORDS);
  localparam logic [31:0] ADDR_IDX_MASK = 32'(NUM_WORDS - 1) << 2;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  mem_req_t             req_q;
  logic [DATA_W-1:0]    mem_q [NUM_WORDS];
  logic                 accept;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic                 do_access;
  logic                 unused_addr_c;

  // Byte-offset and above-range address bits are intentionally dropped.
  assign unused_addr_c = ^(addr & ~ADDR_IDX_MASK);

  assign accept = (state_q == ST_IDLE) && is_input_valid && (mem_read || mem_write);

  data_mem_responder_latency_counter u_latency_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (CNT_W'(LATENCY - 1)),
    .dec_en     (cnt_dec),
    .zero_c     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_BUSY;
          cnt_load = 1'b1;
        end
      end
      ST_BUSY: begin
        if (cnt_zero) begin
          state_d   = ST_RESP;
          do_access = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured request and registered outputs (derived from next state).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      req_q           <= '0;
      mem_ready       <= 1'b1;
      is_output_valid <= 1'b0;
      is_busy         <= 1'b0;
      dout            <= '0;
    end else begin
      state_q         <= state_d;
      mem_ready       <= (state_d == ST_IDLE);
      is_output_valid <= (state_d == ST_RESP);
      is_busy         <= (state_d != ST_IDLE);
      if (accept) begin
        idx_q          <= addr[2 +: IDX_W];
        req_q.is_write <= mem_write;
        req_q.data     <= din;
      end
      if (do_access && !req_q.is_write) begin
        dout <= mem_q[idx_q];
      end
    end
  end

  // Storage array; cleared on reset so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_access && req_q.is_write) begin
      mem_q[idx_q] <= req_q.data;
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder. It is the memory-side end of the MEM-stage load/store interface.
- The pipeline's MEM stage issues a single request through a valid/ready handshake. This block stores words internally, waits a fixed configurable latency, then returns read data or a write acknowledge with a one-cycle output-valid pulse.
- It replaces the single-cycle data memory when the team moves to stall-on-miss / cache work.

Parameters:
- NUM_WORDS, 16384, number of 32-bit words stored; must be a power of 2.
- LATENCY, 4, clock edges from request acceptance to response; legal range 1..255.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- is_input_valid  input  1  request present this cycle
- addr  input  32  byte address of the access
- mem_read  input  1  request is a load
- mem_write  input  1  request is a store
- din  input  32  store data
- mem_ready  output  1  block can accept a request this cycle
- is_output_valid  output  1  response pulse, one cycle wide
- dout  output  32  load data; valid while is_output_valid=1 for a read
- is_busy  output  1  request in flight (BUSY or RESP state)

Behaviour:
- Reset: reset is synchronous and active-high; clock is clk.
  - All storage words cleared to 0.
  - State goes to IDLE; latency counter cleared to 0.
  - Output reset values: mem_ready=1, is_output_valid=0, dout=0, is_busy=0.
- Addressing:
  - Word index = addr[2 +: log2(NUM_WORDS)].
  - addr[1:0] is ignored, so accesses are word-aligned only.
  - Upper address bits are ignored, so out-of-range addresses wrap modulo NUM_WORDS.
- Acceptance: a request is accepted at a rising edge when is_input_valid=1, mem_ready=1 and (mem_read|mem_write)=1.
  - is_input_valid with neither read nor write set is ignored; state stays IDLE.
- Capture: addr index, din, mem_read and mem_write are registered at acceptance. Later changes on the inputs do not affect the in-flight request.
- If mem_read and mem_write are both set, the request is treated as a write. dout is not updated.
- FSM states are IDLE, BUSY and RESP.
  - IDLE: mem_ready=1. On acceptance, go to BUSY with counter=LATENCY-1.
  - BUSY: mem_ready=0.
    - At each edge with counter!=0, decrement the counter.
    - At the edge with counter==0, perform the access and go to RESP:
      - write: storage[idx] <= captured din.
      - read: dout <= storage[idx].
  - RESP: is_output_valid=1 and mem_ready=0 for exactly one cycle. At the next edge, go to IDLE unconditionally.
- Latency:
  - Acceptance at edge E0 gives is_output_valid=1 in the cycle following edge E0+LATENCY.
  - Throughput is one request per LATENCY+2 cycles.
- dout holds its last read value until the next read completes. It is not cleared by writes or by returning to IDLE.
- Requests presented while mem_ready=0 are not accepted and not queued. The requester must hold is_input_valid until mem_ready=1.
- Reset during BUSY or RESP aborts the request:
  - no write is committed;
  - no is_output_valid pulse is produced;
  - all reset values apply at the next cycle.
- is_output_valid and mem_ready are never high in the same cycle.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - Default constants: DEFAULT_LATENCY, DEFAULT_NUM_WORDS.
  - Word-index width function (clog2).
- One sub-module, latency_counter:
  - inputs: load, load value, decrement enable;
  - output: zero flag;
  - 8-bit wide, synchronous reset.

Test Plan:
- Reset, then write addr=0x10, din=0xDEADBEEF, LATENCY=4 -> mem_ready=0 from the next cycle; is_output_valid=1 exactly 4 edges after acceptance, for one cycle; mem_ready=1 one cycle later.
- After the write above, read addr=0x10 -> dout=0xDEADBEEF coincident with is_output_valid; addr=0x13 also returns 0xDEADBEEF.
- Read addr=0x10 + NUM_WORDS*4 -> returns 0xDEADBEEF (wrap); read of an unwritten address 0x20 -> dout=0.
- Hold is_input_valid=1 with a write to 0x40, value 0x1234, throughout the BUSY window of a prior read -> only the first request is serviced until mem_ready=1; then the write is accepted; exactly 2 output pulses total.
- Assert reset 2 cycles into a write of 0xCAFEF00D to 0x80 -> no is_output_valid pulse; a subsequent read of 0x80 returns 0.
- mem_read=1 and mem_write=1 to 0x44, din=0x55 -> treated as write; dout unchanged; a later read of 0x44 returns 0x55. With LATENCY=1, the pulse comes 1 edge after acceptance.
